// File: rtl/alu_pipe.sv
// Registered, flow-controlled ALU: one output stage with valid/ready handshake,
// architectural flag register, branch-condition evaluation and sticky halt.
module alu_pipe #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            opcode,
  input  logic [3:0]            cc,
  input  logic [DATA_WIDTH-1:0] r1,
  input  logic [DATA_WIDTH-1:0] r2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  branch_valid,
  output logic                  halt,
  output logic [4:0]            status_state
);

  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int F_Z = 4, F_N = 3, F_E = 2, F_P = 1, F_C = 0;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0, OP_LD = 4'd1, OP_STR = 4'd2, OP_BRA = 4'd3, OP_XOR = 4'd4,
    OP_ADD = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7, OP_HLT = 4'd8, OP_CMP = 4'd9
  } op_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic                  branch;
  } beat_t;

  logic                  out_valid_q, out_valid_d;
  beat_t                 beat_q, beat_d;
  logic                  halt_q, halt_d;
  logic [4:0]            flags_q, flags_d;

  logic [DATA_WIDTH-1:0] res;
  logic                  c, borrow, fset, take, big, accept;
  logic [SHW-1:0]        shamt;

  assign in_ready = ~halt_q & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  // Any set bit above the shift-index field means the amount is >= DATA_WIDTH.
  assign big   = |r2[DATA_WIDTH-1:SHW];
  assign shamt = r2[SHW-1:0];

  always_comb begin
    res    = '0;
    c      = 1'b0;
    borrow = 1'b0;
    fset   = 1'b0;
    case (opcode)
      OP_LD, OP_STR: res = r2;
      OP_BRA:        res = r1;
      OP_XOR: begin res = r1 ^ r2; fset = 1'b1; end
      OP_ADD: begin {c, res} = {1'b0, r1} + {1'b0, r2}; fset = 1'b1; end
      OP_SHL: begin res = big ? '0 : (r1 << shamt); fset = 1'b1; end
      OP_SHR: begin res = big ? '0 : (r1 >> shamt); fset = 1'b1; end
      OP_CMP: begin
        {borrow, res} = {1'b0, r1} - {1'b0, r2};
        c    = ~borrow;
        fset = 1'b1;
      end
      default: ;
    endcase
  end

  // Conditions read the committed flags, i.e. the last accepted flag-setting op.
  always_comb begin
    case (cc)
      4'd0:    take = 1'b1;
      4'd1:    take = flags_q[F_P];
      4'd2:    take = flags_q[F_E];
      4'd3:    take = flags_q[F_C];
      4'd4:    take = flags_q[F_N];
      4'd5:    take = flags_q[F_Z];
      4'd6:    take = ~flags_q[F_C];
      4'd7:    take = ~flags_q[F_Z] & ~flags_q[F_N];
      default: take = 1'b0;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    beat_d      = beat_q;
    halt_d      = halt_q;
    flags_d     = flags_q;
    if (accept) begin
      out_valid_d   = 1'b1;
      beat_d.result = res;
      beat_d.branch = (opcode == OP_BRA) & take;
      if (fset) flags_d = {res == '0, res[DATA_WIDTH-1], ~res[0], ^res, c};
      if (opcode == OP_HLT) halt_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      beat_q      <= '0;
      halt_q      <= 1'b0;
      flags_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      beat_q      <= beat_d;
      halt_q      <= halt_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign result       = beat_q.result;
  assign branch_valid = beat_q.branch;
  assign halt         = halt_q;
  assign status_state = flags_q;

endmodule
